gsd_div_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one GoldschmidtDivider instance among NREQ requesters.
- Accepts per-requester fixed-point operand pairs (0.32 format, divisor normalized to [0.5,1)). It captures the winner's operands, pulses the divider start, waits for the divider's ready, and returns the quotient tagged to the winning requester.
- Sits between the client units and the divider. The divider's q, busy and ready outputs connect back to this block.

---
 rtl/gsd_div_arbiter.sv | 175 +++++++++++++++++
 tb/tb_gsd_div_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gsd_div_arbiter.sv
// Round-robin arbiter sharing one Goldschmidt divider among NREQ requesters.
// Optional WAIT watchdog: define GSD_ARB_TIMEOUT_EN (limit set by DIV_TIMEOUT).
module gsd_div_arbiter #(
   parameter int NREQ        = 4,
   parameter int W           = 32,
   parameter int DIV_TIMEOUT = 63
) (
   input  logic            clk,
   input  logic            clrn,
   input  logic [NREQ-1:0] req,
   input  logic [NREQ*W-1:0] req_a,
   input  logic [NREQ*W-1:0] req_b,
   output logic [NREQ-1:0] gnt,
   output logic [NREQ-1:0] rsp_valid,
   output logic [W-1:0]    rsp_q,
   output logic            rsp_err,
   output logic [W-1:0]    div_a,
   output logic [W-1:0]    div_b,
   output logic            div_start,
   input  logic [W-1:0]    div_q,
   input  logic            div_busy,
   input  logic            div_ready,
   output logic            arb_busy
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      DONE
   } state_t;

   state_t          state_q, state_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic [PW-1:0]   ptr_q, ptr_d;
   logic [W-1:0]    div_a_q, div_a_d;
   logic [W-1:0]    div_b_q, div_b_d;
   logic [W-1:0]    rsp_q_q, rsp_q_d;
   logic            rsp_err_q, rsp_err_d;

   logic [W-1:0]    a_arr [NREQ];
   logic [W-1:0]    b_arr [NREQ];
   logic            found;
   logic [PW-1:0]   win;
   logic [PW-1:0]   cand;

   for (genvar g = 0; g < NREQ; g++) begin : g_unpack
      assign a_arr[g] = req_a[g*W +: W];
      assign b_arr[g] = req_b[g*W +: W];
   end

   // Search upward from the slot after the last winner, so it ranks last.
   always_comb begin
      found = 1'b0;
      win   = '0;
      cand  = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = PW'((int'(ptr_q) + k) % NREQ);
         if (!found && req[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

`ifdef GSD_ARB_TIMEOUT_EN
   localparam int CW = ($clog2(DIV_TIMEOUT + 1) > 6) ?
                       $clog2(DIV_TIMEOUT + 1) : 6;

   logic [CW-1:0] cnt_q, cnt_d;
`else
   logic unused_cfg;
   assign unused_cfg = (DIV_TIMEOUT != 0);
`endif

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      ptr_d     = ptr_q;
      div_a_d   = div_a_q;
      div_b_d   = div_b_q;
      rsp_q_d   = rsp_q_q;
      rsp_err_d = rsp_err_q;
`ifdef GSD_ARB_TIMEOUT_EN
      cnt_d     = cnt_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (found && !div_busy) begin
               gnt_d      = '0;
               gnt_d[win] = 1'b1;
               ptr_d      = win;
               div_a_d    = a_arr[win];
               div_b_d    = b_arr[win];
               if (b_arr[win][W-1]) begin
                  state_d = ISSUE;
               end else begin
                  // Unnormalized divisor: answer directly, skip the divider.
                  state_d   = DONE;
                  rsp_q_d   = '1;
                  rsp_err_d = 1'b1;
               end
            end
         end
         ISSUE: begin
            state_d = WAIT;
`ifdef GSD_ARB_TIMEOUT_EN
            cnt_d   = '0;
`endif
         end
         WAIT: begin
            if (div_ready) begin
               state_d   = DONE;
               rsp_q_d   = div_q;
               rsp_err_d = 1'b0;
            end
`ifdef GSD_ARB_TIMEOUT_EN
            else if (cnt_q == CW'(DIV_TIMEOUT - 1)) begin
               state_d   = DONE;
               rsp_q_d   = '0;
               rsp_err_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         DONE: begin
            state_d = IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!clrn) begin
         state_q   <= IDLE;
         gnt_q     <= '0;
         ptr_q     <= PW'(NREQ - 1);
         div_a_q   <= '0;
         div_b_q   <= '0;
         rsp_q_q   <= '0;
         rsp_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         ptr_q     <= ptr_d;
         div_a_q   <= div_a_d;
         div_b_q   <= div_b_d;
         rsp_q_q   <= rsp_q_d;
         rsp_err_q <= rsp_err_d;
      end
   end

`ifdef GSD_ARB_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (!clrn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`endif

   assign gnt       = gnt_q;
   assign rsp_valid = (state_q == DONE) ? gnt_q : '0;
   assign rsp_q     = rsp_q_q;
   assign rsp_err   = rsp_err_q;
   assign div_a     = div_a_q;
   assign div_b     = div_b_q;
   assign div_start = (state_q == ISSUE);
   assign arb_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_gsd_div_arbiter.sv
// Scoreboard bench for gsd_div_arbiter with a latency-5 divider model.
// Timeout scenario compiled in only when GSD_ARB_TIMEOUT_EN is defined.
module tb_gsd_div_arbiter;

   localparam int NREQ = 4;
   localparam int W    = 32;

   logic            clk = 1'b0;
   logic            clrn;
   logic [NREQ-1:0] req;
   logic [NREQ*W-1:0] req_a;
   logic [NREQ*W-1:0] req_b;
   logic [NREQ-1:0] gnt;
   logic [NREQ-1:0] rsp_valid;
   logic [W-1:0]    rsp_q;
   logic            rsp_err;
   logic [W-1:0]    div_a;
   logic [W-1:0]    div_b;
   logic            div_start;
   logic [W-1:0]    div_q;
   logic            div_busy;
   logic            div_ready;
   logic            arb_busy;

   gsd_div_arbiter #(
      .NREQ(NREQ),
      .W(W),
      .DIV_TIMEOUT(10)
   ) dut (
      .clk(clk),
      .clrn(clrn),
      .req(req),
      .req_a(req_a),
      .req_b(req_b),
      .gnt(gnt),
      .rsp_valid(rsp_valid),
      .rsp_q(rsp_q),
      .rsp_err(rsp_err),
      .div_a(div_a),
      .div_b(div_b),
      .div_start(div_start),
      .div_q(div_q),
      .div_busy(div_busy),
      .div_ready(div_ready),
      .arb_busy(arb_busy)
   );

   always #5 clk = ~clk;

   // Divider model: ready in the 5th cycle after the start pulse.
   logic       mdl_en;
   logic       mdl_busy = 1'b0;
   logic [3:0] mdl_cnt  = '0;
   logic       force_ready;
   logic       force_busy;
   int         n_starts = 0;

   always @(posedge clk) begin
      if (!clrn) begin
         mdl_busy <= 1'b0;
         mdl_cnt  <= '0;
      end else if (div_start) begin
         mdl_busy <= 1'b1;
         mdl_cnt  <= 4'd5;
         n_starts <= n_starts + 1;
      end else if (mdl_busy) begin
         mdl_cnt <= mdl_cnt - 4'd1;
         if (mdl_cnt == 4'd1) mdl_busy <= 1'b0;
      end
   end

   assign div_ready = (mdl_en && mdl_busy && mdl_cnt == 4'd1) || force_ready;
   assign div_busy  = mdl_busy || force_busy;
   assign div_q     = div_a;

   typedef struct packed {
      logic [NREQ-1:0] v;
      logic [W-1:0]    q;
      logic            e;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   n_rsp = 0;

   task automatic chk(input string nm, input logic [63:0] got,
                      input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h required %0h", nm, got, exp);
      end
   endtask

   task automatic push(input logic [NREQ-1:0] v, input logic [W-1:0] q,
                       input logic e);
      exp_t x;
      x.v = v;
      x.q = q;
      x.e = e;
      sb.push_back(x);
   endtask

   always @(negedge clk) begin
      exp_t x;
      if (|rsp_valid) begin
         n_rsp++;
         n_cmp++;
         if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_rsp: got v=%b q=%h e=%b required none",
                     rsp_valid, rsp_q, rsp_err);
         end else begin
            x = sb.pop_front();
            if ({rsp_valid, rsp_q, rsp_err} !== x) begin
               n_bad++;
               $display("FAIL rsp: got v=%b q=%h e=%b required v=%b q=%h e=%b",
                        rsp_valid, rsp_q, rsp_err, x.v, x.q, x.e);
            end
         end
      end
   end

   // Counts negedges from c0 until a response shows; -1 on timeout.
   task automatic wait_rsp(input int c0, output int c);
      c = c0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         c++;
         if (|rsp_valid) return;
      end
      c = -1;
      n_cmp++;
      n_bad++;
      $display("FAIL wait_rsp: got no response required one within 100 cycles");
   endtask

   task automatic do_reset();
      clrn = 1'b0;
      repeat (2) @(negedge clk);
      clrn = 1'b1;
   endtask

   task automatic set_op(input int i, input logic [W-1:0] a,
                         input logic [W-1:0] b);
      req_a[i*W +: W] = a;
      req_b[i*W +: W] = b;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish required finish by 200000");
      $fatal(1);
   end

   initial begin
      int c;
      int s0;
      int r0;
      logic [NREQ-1:0] dropped;

      clrn        = 1'b0;
      req         = '0;
      req_a       = '0;
      req_b       = '0;
      mdl_en      = 1'b1;
      force_ready = 1'b0;
      force_busy  = 1'b0;
      do_reset();

      chk("reset_outputs",
          {gnt, rsp_valid, rsp_q, rsp_err, div_a, div_b, div_start, arb_busy},
          '0);

      // Single normalized request.
      set_op(0, 32'hC000_0000, 32'h8000_0000);
      push(4'b0001, 32'hC000_0000, 1'b0);
      s0  = n_starts;
      req = 4'b0001;
      @(negedge clk);
      chk("t1_start", div_start, 1);
      chk("t1_div_a", div_a, 32'hC000_0000);
      chk("t1_div_b", div_b, 32'h8000_0000);
      chk("t1_gnt", gnt, 4'b0001);
      @(negedge clk);
      chk("t1_start_pulse", div_start, 0);
      wait_rsp(2, c);
      chk("t1_latency", c, 7);
      req = '0;
      @(negedge clk);
      chk("t1_nstarts", n_starts - s0, 1);

      // All four requesting: round-robin 0,1,2,3,0.
      do_reset();
      for (int i = 0; i < NREQ; i++)
         set_op(i, 32'h1000_0000 * (i + 1), 32'h8000_0000 | i);
      push(4'b0001, 32'h1000_0000, 1'b0);
      push(4'b0010, 32'h2000_0000, 1'b0);
      push(4'b0100, 32'h3000_0000, 1'b0);
      push(4'b1000, 32'h4000_0000, 1'b0);
      push(4'b0001, 32'h1000_0000, 1'b0);
      s0  = n_starts;
      req = 4'b1111;
      for (int n = 0; n < 5; n++) begin
         wait_rsp(0, c);
         if (c < 0) break;
         dropped = rsp_valid;
         req     = (n == 4) ? '0 : (req & ~dropped);
         repeat (2) @(negedge clk);
         if (n < 4) req = req | dropped;
      end
      req = '0;
      repeat (3) @(negedge clk);
      chk("rr_nstarts", n_starts - s0, 5);

      // Unnormalized divisor on requester 2.
      set_op(2, 32'h1234_0000, 32'h4000_0000);
      push(4'b0100, 32'hFFFF_FFFF, 1'b1);
      s0  = n_starts;
      req = 4'b0100;
      wait_rsp(0, c);
      chk("unnorm_latency", c, 1);
      chk("unnorm_no_start", div_start, 0);
      req = '0;
      @(negedge clk);
      chk("unnorm_nstarts", n_starts - s0, 0);

      // Operand change while in WAIT.
      set_op(1, 32'h3456_7890, 32'h9000_0000);
      push(4'b0010, 32'h3456_7890, 1'b0);
      req = 4'b0010;
      repeat (3) @(negedge clk);
      set_op(1, 32'hDEAD_BEEF, 32'h0000_0000);
      @(negedge clk);
      chk("opchg_div_a", div_a, 32'h3456_7890);
      chk("opchg_div_b", div_b, 32'h9000_0000);
      wait_rsp(4, c);
      chk("opchg_latency", c, 7);
      req = '0;
      @(negedge clk);

      // Stray div_ready in IDLE, then in ISSUE.
      r0          = n_rsp;
      force_ready = 1'b1;
      repeat (3) @(negedge clk);
      force_ready = 1'b0;
      @(negedge clk);
      chk("idle_ready_norsp", n_rsp - r0, 0);
      chk("idle_ready_state", arb_busy, 0);
      set_op(3, 32'h0ABC_0000, 32'hFFFF_FFFF);
      push(4'b1000, 32'h0ABC_0000, 1'b0);
      req = 4'b1000;
      @(negedge clk);
      force_ready = 1'b1;
      @(negedge clk);
      force_ready = 1'b0;
      wait_rsp(2, c);
      chk("issue_ready_latency", c, 7);
      req = '0;
      @(negedge clk);

      // Reset in WAIT abandons the transaction and restores the pointer.
      set_op(2, 32'h1234_5678, 32'h8000_0001);
      r0  = n_rsp;
      req = 4'b0100;
      repeat (3) @(negedge clk);
      clrn = 1'b0;
      @(negedge clk);
      chk("midrst_outputs",
          {gnt, rsp_valid, rsp_q, rsp_err, div_a, div_b, div_start, arb_busy},
          '0);
      clrn = 1'b1;
      req  = '0;
      repeat (8) @(negedge clk);
      chk("midrst_norsp", n_rsp - r0, 0);
      set_op(0, 32'h5555_0000, 32'hA000_0000);
      set_op(3, 32'h7777_0000, 32'hB000_0000);
      push(4'b0001, 32'h5555_0000, 1'b0);
      push(4'b1000, 32'h7777_0000, 1'b0);
      req = 4'b1001;
      wait_rsp(0, c);
      req = req & ~rsp_valid;
      wait_rsp(0, c);
      req = req & ~rsp_valid;
      @(negedge clk);

`ifdef GSD_ARB_TIMEOUT_EN
      // Divider never answers; requester 1 waits for busy to fall.
      set_op(0, 32'h1111_0000, 32'h8000_0000);
      set_op(1, 32'h2222_0000, 32'hC000_0000);
      push(4'b0001, 32'h0000_0000, 1'b1);
      push(4'b0010, 32'h2222_0000, 1'b0);
      mdl_en = 1'b0;
      req    = 4'b0011;
      @(negedge clk);
      force_busy = 1'b1;
      @(negedge clk);
      s0 = n_starts;
      wait_rsp(2, c);
      chk("tmo_latency", c, 12);
      req    = req & ~rsp_valid;
      mdl_en = 1'b1;
      while (c < 21) begin
         @(negedge clk);
         c++;
      end
      chk("tmo_blocked_by_busy", n_starts - s0, 0);
      force_busy = 1'b0;
      wait_rsp(21, c);
      chk("tmo_next_latency", c, 28);
      req = '0;
      @(negedge clk);
`endif

      repeat (5) @(negedge clk);
      chk("sb_empty", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
